// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the parameterized synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Occupancy needs one extra bit so that "full" (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy flags, overflow/underflow pulses and optional FWFT read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_enable,
  input  logic                      read_enable,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   fill_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc, rd_acc;

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign rd_acc = read_enable && !fifo_empty;
  assign wr_acc = write_enable && (!fifo_full || rd_acc);

  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign fill_count   = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= write_enable && !wr_acc;
      underflow <= read_enable && fifo_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (write_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry is shown directly; zero while empty so reset presents zero.
    assign read_data = fifo_empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    rd_q <= '0;
      else if (rd_acc) rd_q <= ram_rdata;
    end
    assign read_data = rd_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed + random check of sync_fifo_param (standard and FWFT instances) against a queue model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          write_enable, read_enable;
  logic [DW-1:0] write_data;

  logic [DW-1:0] rd0, rd1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [CW-1:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd0;
  logic          exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .read_data(rd0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fill_count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .read_data(rd1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fill_count(cnt1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares every output of both instances against the model's view of occupancy.
  task automatic check_all(input string tag);
    int n;
    logic [5:0] flags;
    n = q.size();
    flags = {n == DEPTH, n == 0, n >= AF, n <= AE, exp_ovf, exp_unf};
    chk({tag, " cnt0"},  32'(cnt0), 32'(n));
    chk({tag, " cnt1"},  32'(cnt1), 32'(n));
    chk({tag, " flags0"}, 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(flags));
    chk({tag, " flags1"}, 32'({full1, empty1, af1, ae1, ovf1, unf1}), 32'(flags));
    chk({tag, " rd0"},   32'(rd0), 32'(exp_rd0));
    if (n > 0) chk({tag, " rd1"}, 32'(rd1), 32'(q[0]));
  endtask

  task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] wd);
    bit rd_ok, wr_ok;
    write_enable = we;
    read_enable  = re;
    write_data   = wd;
    @(posedge clk);
    #1;
    rd_ok   = re && (q.size() > 0);
    wr_ok   = we && (q.size() < DEPTH || rd_ok);
    exp_unf = re && (q.size() == 0);
    exp_ovf = we && !wr_ok;
    if (rd_ok) exp_rd0 = q.pop_front();
    if (wr_ok) q.push_back(wd);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd0 = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    write_enable = 1'b0;
    read_enable = 1'b0;
    write_data = '0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Two writes then two reads, standard-mode one-cycle read latency.
    step("w_ca", 1, 0, 8'hCA);
    step("w_aa", 1, 0, 8'hAA);
    step("r_ca", 0, 1, 8'h00);
    step("r_aa", 0, 1, 8'h00);

    // Fill to full, overflow attempt, drain.
    for (int i = 1; i <= 4; i++) step("fill", 1, 0, DW'(i));
    step("ovf", 1, 0, 8'hEE);
    step("ovf_clr", 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, 8'h00);

    // Empty-side corner cases.
    step("unf", 0, 1, 8'h00);
    step("unf_clr", 0, 0, 8'h00);
    step("wr_rd_empty", 1, 1, 8'h77);
    step("rd_77", 0, 1, 8'h00);

    // Full with simultaneous write + read.
    for (int i = 0; i < 4; i++) step("fill2", 1, 0, DW'(8'h10 + i));
    step("full_wr_rd", 1, 1, 8'h55);
    for (int i = 0; i < 4; i++) step("drain2", 0, 1, 8'h00);

    // Interleaved write/read runs to exercise pointer wrap.
    for (int r = 0; r < 2; r++)
      for (int i = 1; i <= 6; i++) begin
        step("wrap_w", 1, 0, DW'(i + 16 * r));
        step("wrap_r", 0, 1, 8'h00);
      end

    // Asynchronous reset while three words are held.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, DW'(8'hA0 + i));
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    reset_n = 1'b1;
    step("post_rst_w", 1, 0, 8'h01);
    step("post_rst_r", 0, 1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 standard, 1 first-word-fall-through).
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port write_enable  input  1  write request.
REQ-009 SHALL have port read_enable  input  1  read request (FWFT: pop head).
REQ-010 SHALL have port write_data  input  DATA_WIDTH  write word.
REQ-011 SHALL have port read_data  output  DATA_WIDTH  read word.
REQ-012 SHALL have port fifo_full  output  1  count == DEPTH.
REQ-013 SHALL have port fifo_empty  output  1  count == 0.
REQ-014 SHALL have port almost_full  output  1  count >= AF_THRESH.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_THRESH.
REQ-016 SHALL have port fill_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse, rejected write.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse, rejected read.

Function
REQ-019 Write SHALL be accepted on a rising edge when write_enable=1 and (fifo_full=0 or read accepted same edge); word stored at write pointer, pointer +1 mod DEPTH.
REQ-020 Read SHALL be accepted when read_enable=1 and fifo_empty=0; read pointer +1 mod DEPTH.
REQ-021 fill_count SHALL change +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read+write or neither.
REQ-022 All flags SHALL be decoded from the registered count and reflect it in the same cycle fill_count does.
REQ-023 Full + write + read SHALL accept both; count stays DEPTH; no overflow.
REQ-024 Empty + write + read SHALL accept write only; count becomes 1; underflow pulses.
REQ-025 overflow SHALL assert for exactly the cycle after an edge with write_enable=1, fifo_full=1, read_enable=0; FIFO contents unchanged.
REQ-026 underflow SHALL assert for exactly the cycle after an edge with read_enable=1, fifo_empty=1; pointers unchanged.
REQ-027 FWFT=0: read_data SHALL update one cycle after an accepted read (registered) and hold its value otherwise.
REQ-028 FWFT=1: read_data SHALL present the head entry whenever fifo_empty=0, zero latency; a word written into an empty FIFO SHALL appear the cycle after the write edge.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without data loss; data order strictly first-in first-out.

Reset
REQ-030 reset_n=0 SHALL asynchronously clear pointers and count; fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fill_count=0, overflow=0, underflow=0, read_data=0.
REQ-031 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-032 Release SHALL be on the reset_n deassertion; first operation accepted on the next rising edge.

Structure
REQ-033 Shared package fifo_pkg SHALL hold default DATA_WIDTH/DEPTH constants and a count-width function ($clog2(DEPTH)+1).
REQ-034 Storage SHALL be a sub-module fifo_ram (1 write port, 1 async read port, no reset); control, pointers, and flags in sync_fifo_param.
REQ-035 Elaboration SHALL fail for DEPTH not power of two or thresholds out of range.

Verification (DATA_WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-036 Write 0xCA, 0xAA, then two reads, FWFT=0 -> read_data 0xCA then 0xAA, each one cycle after read; fifo_empty=1 after.
REQ-037 Write 4 words 0x01..0x04 -> almost_full at count 3, fifo_full at 4; 5th write -> overflow one cycle, reads return 0x01..0x04.
REQ-038 Read on empty -> underflow one cycle, fill_count stays 0; simultaneous write+read on empty -> count 1, underflow pulses.
REQ-039 Full, simultaneous write 0x55 + read -> count stays 4, no overflow, oldest word out, 0x55 read last.
REQ-040 Write 6 / read 6 interleaved twice (pointer wrap) -> data order preserved; FWFT=1 -> read_data=0x01 the cycle after first write.
REQ-041 reset_n low while count=3 -> flags and fill_count return to reset values immediately, before any clock edge.
